// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared constants, FSM state type and the CRC7 step function for the
// card-side CMD line responder.
package sd_card_cmd_responder_pkg;

   localparam int         SD_CMD_LEN   = 48;
   localparam logic [6:0] SD_CRC7_POLY = 7'h09;

   typedef enum logic [2:0] {
      CRSP_IDLE,
      CRSP_RECV,
      CRSP_CHECK,
      CRSP_WAIT,
      CRSP_SEND
   } crsp_state_e;

   // One bit of the x^7 + x^3 + 1 shift-register CRC, MSB-first data.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_card_cmd_responder_crc7_serial.sv
// Bit-serial CRC7 accumulator: clear wins over enable, value held otherwise.
module crc7_serial
   import sd_card_cmd_responder_pkg::*;
(
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       din_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc7_step(crc_q, din_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit host commands, checks framing/CRC7,
// and answers non-CMD0 commands with an index/status/CRC7 response after NCR.
module sd_card_cmd_responder
   import sd_card_cmd_responder_pkg::*;
#(
   parameter int NCR = 2
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        cmd_from_host,
   input  logic [31:0] card_status,
   output logic        cmd_to_host,
   output logic        cmd_to_host_oe,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index_out,
   output logic [31:0] cmd_arg_out,
   output logic        crc_error,
   output logic        busy
);

   localparam logic [5:0] RX_LOAD   = 6'(SD_CMD_LEN - 2);
   localparam logic [5:0] TX_LOAD   = 6'(SD_CMD_LEN - 1);
   localparam logic [5:0] WAIT_LOAD = 6'(NCR - 2);

   crsp_state_e state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [46:0] rx_sr_q, rx_sr_d;
   logic [39:0] tx_sr_q, tx_sr_d;
   logic [5:0]  index_q, index_d;
   logic [31:0] arg_q, arg_d;
   logic        valid_q, valid_d;
   logic        crc_err_q, crc_err_d;
   logic        busy_q, busy_d;
   logic        out_q, out_d;
   logic        oe_q, oe_d;

   logic        rx_crc_clr, rx_crc_en;
   logic        tx_crc_clr, tx_crc_en;
   logic [6:0]  rx_crc, tx_crc;
   logic        frame_good;
   logic [5:0]  nxt_bit;
   logic [2:0]  crc_sel;

   crc7_serial u_rx_crc (
      .clk_i  (CLK),
      .srst_i (RESET),
      .clr_i  (rx_crc_clr),
      .en_i   (rx_crc_en),
      .din_i  (cmd_from_host),
      .crc_o  (rx_crc)
   );

   crc7_serial u_tx_crc (
      .clk_i  (CLK),
      .srst_i (RESET),
      .clr_i  (tx_crc_clr),
      .en_i   (tx_crc_en),
      .din_i  (tx_sr_q[39]),
      .crc_o  (tx_crc)
   );

   // rx_sr holds bits 46..0: [46] dir, [45:40] index, [39:8] arg, [7:1] crc, [0] end.
   assign frame_good = rx_sr_q[46] & rx_sr_q[0] & (rx_sr_q[7:1] == rx_crc);
   // In SEND cnt_q is the bit currently on the wire; nxt_bit is the one to drive next.
   assign nxt_bit    = cnt_q - 6'd1;
   assign crc_sel    = nxt_bit[2:0] - 3'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      index_d    = index_q;
      arg_d      = arg_q;
      valid_d    = 1'b0;
      crc_err_d  = 1'b0;
      out_d      = 1'b1;
      oe_d       = 1'b0;
      rx_crc_clr = 1'b0;
      rx_crc_en  = 1'b0;
      tx_crc_clr = 1'b0;
      tx_crc_en  = 1'b0;

      case (state_q)
         CRSP_IDLE: begin
            rx_crc_clr = 1'b1;
            tx_crc_clr = 1'b1;
            if (!cmd_from_host) begin
               state_d = CRSP_RECV;
               cnt_d   = RX_LOAD;
            end
         end
         CRSP_RECV: begin
            rx_sr_d   = {rx_sr_q[45:0], cmd_from_host};
            // Start bit is zero so skipping it leaves the CRC unchanged.
            rx_crc_en = (cnt_q >= 6'd8);
            if (cnt_q == 6'd0) begin
               state_d = CRSP_CHECK;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         CRSP_CHECK: begin
            tx_crc_clr = 1'b1;
            if (frame_good) begin
               valid_d = 1'b1;
               index_d = rx_sr_q[45:40];
               arg_d   = rx_sr_q[39:8];
               if (rx_sr_q[45:40] == 6'd0) begin
                  state_d = CRSP_IDLE;
               end else begin
                  state_d = CRSP_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               crc_err_d = 1'b1;
               state_d   = CRSP_IDLE;
            end
         end
         CRSP_WAIT: begin
            tx_crc_clr = 1'b1;
            if (cnt_q == 6'd0) begin
               state_d = CRSP_SEND;
               cnt_d   = TX_LOAD;
               tx_sr_d = {1'b0, index_q, card_status, 1'b0};
               out_d   = 1'b0;
               oe_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         CRSP_SEND: begin
            if (cnt_q == 6'd0) begin
               state_d = CRSP_IDLE;
            end else begin
               oe_d  = 1'b1;
               cnt_d = nxt_bit;
               if (nxt_bit >= 6'd8) begin
                  out_d     = tx_sr_q[39];
                  tx_sr_d   = {tx_sr_q[38:0], 1'b0};
                  tx_crc_en = 1'b1;
               end else if (nxt_bit != 6'd0) begin
                  out_d = tx_crc[crc_sel];
               end
            end
         end
         default: begin
            state_d = CRSP_IDLE;
         end
      endcase

      busy_d = (state_d != CRSP_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= CRSP_IDLE;
         cnt_q     <= '0;
         rx_sr_q   <= '0;
         tx_sr_q   <= '0;
         index_q   <= '0;
         arg_q     <= '0;
         valid_q   <= 1'b0;
         crc_err_q <= 1'b0;
         busy_q    <= 1'b0;
         out_q     <= 1'b1;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_sr_q   <= rx_sr_d;
         tx_sr_q   <= tx_sr_d;
         index_q   <= index_d;
         arg_q     <= arg_d;
         valid_q   <= valid_d;
         crc_err_q <= crc_err_d;
         busy_q    <= busy_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
      end
   end

   assign cmd_to_host    = out_q;
   assign cmd_to_host_oe = oe_q;
   assign cmd_valid      = valid_q;
   assign cmd_index_out  = index_q;
   assign cmd_arg_out    = arg_q;
   assign crc_error      = crc_err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Bench for the SD card CMD responder: directed and random command frames
// checked against a frame-level model (polynomial-division CRC7).
module tb_sd_card_cmd_responder;

   localparam int NCR = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        cmd_from_host;
   logic [31:0] card_status;
   logic        cmd_to_host;
   logic        cmd_to_host_oe;
   logic        cmd_valid;
   logic [5:0]  cmd_index_out;
   logic [31:0] cmd_arg_out;
   logic        crc_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [5:0]  exp_idx;
   logic [31:0] exp_arg;

   sd_card_cmd_responder #(.NCR(NCR)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .cmd_from_host  (cmd_from_host),
      .card_status    (card_status),
      .cmd_to_host    (cmd_to_host),
      .cmd_to_host_oe (cmd_to_host_oe),
      .cmd_valid      (cmd_valid),
      .cmd_index_out  (cmd_index_out),
      .cmd_arg_out    (cmd_arg_out),
      .crc_error      (crc_error),
      .busy           (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7_of(input logic [39:0] d);
      logic [46:0] r;
      r = {d, 7'b0};
      for (int i = 46; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [47:0] make_frame(input logic dir, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic endb);
      logic [39:0] body;
      body = {1'b0, dir, idx, arg};
      return {body, crc7_of(body), endb};
   endfunction

   // Drives one host frame starting at the current negedge, then checks
   // decode, response timing/content. rst_bit>0 pulses RESET at that response bit.
   task automatic do_cmd(input logic [47:0] frame, input logic [31:0] status,
                         input int rst_bit, output logic [47:0] resp_o);
      logic        good;
      logic        has_resp;
      logic [39:0] rbody;
      logic [47:0] exp_resp;
      logic [47:0] cap;
      int          k;
      int          n;

      good     = frame[46] && frame[0] && (crc7_of(frame[47:8]) == frame[7:1]);
      has_resp = good && (frame[45:40] != 6'd0);
      rbody    = {2'b00, frame[45:40], status};
      exp_resp = {rbody, crc7_of(rbody), 1'b1};
      resp_o   = '1;
      $display("txn frame=%h status=%h good=%0b responds=%0b", frame, status, good, has_resp);

      card_status = status;
      for (int i = 47; i >= 0; i--) begin
         cmd_from_host = frame[i];
         @(negedge CLK);
      end
      cmd_from_host = 1'b1;
      chk("busy_in_check", 64'(busy), 64'(1));
      @(negedge CLK);

      if (good) begin
         exp_idx = frame[45:40];
         exp_arg = frame[39:8];
      end
      chk("cmd_valid", 64'(cmd_valid), 64'(good));
      chk("crc_error", 64'(crc_error), 64'(!good));
      chk("index_out", 64'(cmd_index_out), 64'(exp_idx));
      chk("arg_out", 64'(cmd_arg_out), 64'(exp_arg));
      chk("busy_after_check", 64'(busy), 64'(has_resp));

      if (!has_resp) begin
         n = 0;
         repeat (60) begin
            @(negedge CLK);
            if (cmd_to_host_oe || !cmd_to_host) n++;
         end
         chk("no_response", 64'(n), 64'(0));
         return;
      end

      k = 1;
      while (!cmd_to_host_oe && k < 100) begin
         @(negedge CLK);
         k++;
      end
      chk("resp_start_delay", 64'(k), 64'(NCR));
      if (!cmd_to_host_oe) return;

      cap = '0;
      n   = 0;
      while (cmd_to_host_oe && n < 60) begin
         cap = {cap[46:0], cmd_to_host};
         n++;
         if (n == rst_bit) begin
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            exp_idx = '0;
            exp_arg = '0;
            chk("rst_oe", 64'(cmd_to_host_oe), 64'(0));
            chk("rst_cmd", 64'(cmd_to_host), 64'(1));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_index", 64'(cmd_index_out), 64'(0));
            resp_o = cap;
            return;
         end
         @(negedge CLK);
      end
      resp_o = cap;
      chk("oe_length", 64'(n), 64'(48));
      chk("response", 64'(cap), 64'(exp_resp));
      chk("released_line", 64'(cmd_to_host), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));
   endtask

   initial begin
      logic [47:0] r;
      logic [47:0] f;
      logic [5:0]  ridx;
      logic [31:0] rarg;
      int          kind;

      RESET         = 1'b1;
      cmd_from_host = 1'b1;
      card_status   = '0;
      exp_idx       = '0;
      exp_arg       = '0;
      repeat (3) @(negedge CLK);
      chk("reset_cmd", 64'(cmd_to_host), 64'(1));
      chk("reset_oe", 64'(cmd_to_host_oe), 64'(0));
      chk("reset_valid", 64'(cmd_valid), 64'(0));
      chk("reset_crcerr", 64'(crc_error), 64'(0));
      chk("reset_index", 64'(cmd_index_out), 64'(0));
      chk("reset_arg", 64'(cmd_arg_out), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      // CMD8 with the well-known response
      do_cmd(48'h48_000001AA_87, 32'h0000_01AA, -1, r);
      chk("cmd8_resp_literal", 64'(r), 64'(48'h08_000001AA_13));
      repeat (2) @(negedge CLK);

      // CMD0: decoded, no response
      do_cmd(48'h40_00000000_95, 32'h1234_5678, -1, r);

      // Bad CRC byte, bad end bit, dir=0, line held low
      do_cmd(48'h48_000001AA_86, 32'h0000_01AA, -1, r);
      f = 48'h48_000001AA_87;
      f[0] = 1'b0;
      do_cmd(f, 32'h0, -1, r);
      do_cmd(make_frame(1'b0, 6'd8, 32'h0000_01AA, 1'b1), 32'h0, -1, r);
      do_cmd(48'h0, 32'h0, -1, r);

      // Reset mid-response, then a normal CMD8
      do_cmd(make_frame(1'b1, 6'd17, 32'hDEAD_BEEF, 1'b1), 32'hCAFE_0001, 20, r);
      do_cmd(48'h48_000001AA_87, 32'h0000_01AA, -1, r);

      // Back-to-back: second start bit on the first IDLE cycle
      do_cmd(make_frame(1'b1, 6'd8, 32'h0000_0155, 1'b1), 32'hA5A5_0F0F, -1, r);
      do_cmd(make_frame(1'b1, 6'd8, 32'h0000_02AA, 1'b1), 32'h5A5A_F0F0, -1, r);

      // Random commands and corruptions
      for (int t = 0; t < 14; t++) begin
         ridx = 6'($urandom_range(0, 63));
         rarg = $urandom;
         kind = int'($urandom_range(0, 4));
         f = make_frame(1'b1, ridx, rarg, 1'b1);
         if (kind == 3) f = f ^ (48'h2 << $urandom_range(0, 6));
         if (kind == 4) f[0] = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         do_cmd(f, $urandom, -1, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
